// File: rtl/wave_sequencer.sv
// rtl/wave_sequencer.sv - wave-channel sample sequencer with wave-RAM fetch, volume scaling and length counter
//
// Ports:
//   system_clock    single clock, rising-edge state updates
//   reset           asynchronous active-low reset
//   timer_tick      one-cycle strobe at the channel base rate (period timer step)
//   length_tick     one-cycle strobe at the length-counter rate
//   NR30..NR34      channel register values (DAC/bank, length, volume, freq lo, freq hi/control)
//   nr31_wr         one-cycle strobe: NR31 written, reload length counter
//   nr34_wr         one-cycle strobe: NR34 written, trigger when NR34[7] is set
//   rd_req/rd_addr  wave-RAM read request and byte address {bank, byte[3:0]}
//   rd_valid        read completion, rd_data valid in the same cycle
//   rd_data         wave-RAM byte, high nibble is the even sample
//   sample_out      volume-scaled sample, unsigned 0..60
//   position        current sample index
//   channel_active  channel enabled status
module wave_sequencer #(
    parameter int FREQ_W = 11
) (
    input  logic       system_clock,
    input  logic       reset,
    input  logic       timer_tick,
    input  logic       length_tick,
    input  logic [7:0] NR30,
    input  logic [7:0] NR31,
    input  logic [7:0] NR32,
    input  logic [7:0] NR33,
    input  logic [7:0] NR34,
    input  logic       nr31_wr,
    input  logic       nr34_wr,
    output logic       rd_req,
    output logic [4:0] rd_addr,
    input  logic       rd_valid,
    input  logic [7:0] rd_data,
    output logic [5:0] sample_out,
    output logic [5:0] position,
    output logic       channel_active
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FETCH = 2'd2
    } state_t;

    localparam logic [FREQ_W-1:0] TIMER_MAX = {FREQ_W{1'b1}};
    localparam logic [FREQ_W-1:0] TIMER_ONE = FREQ_W'(1);

    state_t            state, state_n;
    logic [FREQ_W-1:0] timer, timer_n;
    logic [8:0]        length, length_n;
    logic [5:0]        position_n;
    logic [5:0]        sample_n;
    logic [4:0]        addr_n;
    logic              req_n;
    logic              active_n;
    // Set when the position moved on while a read was outstanding: the
    // data that eventually returns belongs to an old sample and is dropped.
    logic              stale, stale_n;

    logic              dac_on;
    logic              trigger;
    logic              advance;
    logic              expire;
    logic [5:0]        pos_adv;
    logic [3:0]        nibble;
    logic [5:0]        scaled;
    logic [FREQ_W-1:0] freq;

    logic unused_bits;
    assign unused_bits = ^{NR30[4:0], NR32[4:0], NR34[5:3]};

    // In dual-bank mode (NR30[5]) position[5] flips the selected bank so a
    // 64-sample pass plays the NR30[6] bank first, then the other one.
    function automatic logic [4:0] addr_of(input logic [5:0] p, input logic [7:0] nr30);
        logic bank;
        bank = nr30[5] ? (nr30[6] ^ p[5]) : nr30[6];
        return {bank, p[4:1]};
    endfunction

    assign dac_on  = NR30[7];
    assign trigger = nr34_wr & NR34[7];
    assign freq    = FREQ_W'({NR34[2:0], NR33});
    assign advance = (state != IDLE) && timer_tick && (timer == TIMER_MAX);
    assign pos_adv = NR30[5] ? (position + 6'd1) : {1'b0, position[4:0] + 5'd1};
    assign nibble  = position[0] ? rd_data[3:0] : rd_data[7:4];

    always_comb begin
        scaled = 6'd0;
        if (NR32[7]) begin
            scaled = {2'b00, nibble} + {1'b0, nibble, 1'b0};
        end else begin
            case (NR32[6:5])
                2'b01:   scaled = {nibble, 2'b00};
                2'b10:   scaled = {1'b0, nibble, 1'b0};
                2'b11:   scaled = {2'b00, nibble};
                default: scaled = 6'd0;
            endcase
        end
    end

    always_comb begin
        state_n    = state;
        timer_n    = timer;
        length_n   = length;
        position_n = position;
        sample_n   = sample_out;
        addr_n     = rd_addr;
        req_n      = rd_req;
        active_n   = channel_active;
        stale_n    = stale;
        expire     = 1'b0;

        // Length counter: a register write or a trigger takes the cycle,
        // so a coincident length_tick is not applied.
        if (nr31_wr) begin
            length_n = 9'd256 - {1'b0, NR31};
        end else if (trigger && dac_on) begin
            if (length == 9'd0) begin
                length_n = 9'd256;
            end
        end else if (length_tick && NR34[6] && (length != 9'd0)) begin
            length_n = length - 9'd1;
            expire   = (length == 9'd1);
        end

        if (!dac_on) begin
            state_n  = IDLE;
            active_n = 1'b0;
            sample_n = 6'd0;
            req_n    = 1'b0;
            stale_n  = 1'b0;
        end else if (trigger) begin
            state_n    = FETCH;
            active_n   = 1'b1;
            position_n = 6'd0;
            timer_n    = freq;
            if (rd_req && !rd_valid) begin
                // Address must stay put until the old read completes;
                // the position-0 read is issued when it does.
                stale_n = 1'b1;
            end else begin
                req_n   = 1'b1;
                addr_n  = addr_of(6'd0, NR30);
                stale_n = 1'b0;
            end
        end else if (expire) begin
            // An outstanding read is still allowed to complete in IDLE.
            state_n  = IDLE;
            active_n = 1'b0;
            stale_n  = 1'b0;
            if (rd_req && rd_valid) begin
                req_n = 1'b0;
            end
        end else begin
            if ((state != IDLE) && timer_tick) begin
                timer_n = (timer == TIMER_MAX) ? freq : (timer + TIMER_ONE);
            end
            case (state)
                IDLE: begin
                    if (rd_req && rd_valid) begin
                        req_n = 1'b0;
                    end
                end
                RUN: begin
                    if (advance) begin
                        position_n = pos_adv;
                        state_n    = FETCH;
                        req_n      = 1'b1;
                        addr_n     = addr_of(pos_adv, NR30);
                        stale_n    = 1'b0;
                    end
                end
                FETCH: begin
                    if (advance) begin
                        position_n = pos_adv;
                    end
                    if (rd_valid) begin
                        if (stale || advance) begin
                            addr_n  = addr_of(position_n, NR30);
                            stale_n = 1'b0;
                        end else begin
                            sample_n = scaled;
                            req_n    = 1'b0;
                            state_n  = RUN;
                        end
                    end else if (advance) begin
                        stale_n = 1'b1;
                    end
                end
                default: begin
                    state_n = IDLE;
                    req_n   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge system_clock or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            timer          <= '0;
            length         <= 9'd0;
            position       <= 6'd0;
            sample_out     <= 6'd0;
            rd_addr        <= 5'd0;
            rd_req         <= 1'b0;
            channel_active <= 1'b0;
            stale          <= 1'b0;
        end else begin
            state          <= state_n;
            timer          <= timer_n;
            length         <= length_n;
            position       <= position_n;
            sample_out     <= sample_n;
            rd_addr        <= addr_n;
            rd_req         <= req_n;
            channel_active <= active_n;
            stale          <= stale_n;
        end
    end

endmodule
